// File: rtl/scoreboard_register_file.sv
// Register file with per-register busy bit and producer tag; dispatch reserves, write-back releases.
// Optional macro REGFILE_WB_BYPASS_EN forwards a matching write-back straight onto the read ports.
module scoreboard_register_file #(
   parameter int OPERAND_WIDTH  = 32,
   parameter int NUM_REGS       = 32,
   parameter int NUM_READ_PORTS = 2,
   parameter int TAG_WIDTH      = 4
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        rsv_valid,
   input  logic [$clog2(NUM_REGS)-1:0]                 rsv_addr,
   input  logic [TAG_WIDTH-1:0]                        rsv_tag,
   input  logic                                        wb_valid,
   input  logic [TAG_WIDTH-1:0]                        wb_tag,
   input  logic [OPERAND_WIDTH-1:0]                    wb_data,
   input  logic                                        flush,
   input  logic [NUM_READ_PORTS*$clog2(NUM_REGS)-1:0]  rd_addr,
   output logic [NUM_READ_PORTS*OPERAND_WIDTH-1:0]     rd_data,
   output logic [NUM_READ_PORTS-1:0]                   rd_busy,
   output logic [NUM_READ_PORTS*TAG_WIDTH-1:0]         rd_tag,
   output logic [$clog2(NUM_REGS+1)-1:0]               busy_count
);

   localparam int AW = $clog2(NUM_REGS);
   localparam int CW = $clog2(NUM_REGS + 1);

   // Handshake: rsv_valid and wb_valid are single-cycle qualifiers sampled on the rising
   // edge; there is no back-pressure, every qualified request is accepted that cycle.

   logic [NUM_REGS-1:0][OPERAND_WIDTH-1:0] data_q, data_d;
   logic [NUM_REGS-1:0][TAG_WIDTH-1:0]     tag_q, tag_d;
   logic [NUM_REGS-1:0]                    busy_q, busy_d;
   logic [NUM_REGS-1:0]                    wb_hit, rsv_hit;
   logic [CW-1:0]                          count_d;
   logic                                   rsv_live;

   logic [NUM_READ_PORTS-1:0][AW-1:0]      port_addr;

   assign rsv_live  = rsv_valid && !flush && (rsv_addr != '0);
   assign port_addr = rd_addr;

   always_comb begin
      wb_hit  = '0;
      rsv_hit = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         wb_hit[r]  = wb_valid && busy_q[r] && (tag_q[r] == wb_tag);
         rsv_hit[r] = rsv_live && (rsv_addr == AW'(r));
      end
   end

   // Priority per register: flush clears busy, then a reservation beats a write-back.
   always_comb begin
      data_d  = data_q;
      tag_d   = tag_q;
      busy_d  = busy_q;
      count_d = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (wb_hit[r] && !rsv_hit[r]) data_d[r] = wb_data;
         if (rsv_hit[r])               tag_d[r]  = rsv_tag;
         if (flush)                    busy_d[r] = 1'b0;
         else if (rsv_hit[r])          busy_d[r] = 1'b1;
         else if (wb_hit[r])           busy_d[r] = 1'b0;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
         count_d = count_d + CW'(busy_d[r]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q     <= '0;
         tag_q      <= '0;
         busy_q     <= '0;
         busy_count <= '0;
      end else begin
         data_q     <= data_d;
         tag_q      <= tag_d;
         busy_q     <= busy_d;
         busy_count <= count_d;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      rd_tag  = '0;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
         if (port_addr[p] != '0) begin
            rd_data[p*OPERAND_WIDTH +: OPERAND_WIDTH] = data_q[port_addr[p]];
            rd_busy[p]                                = busy_q[port_addr[p]];
            rd_tag[p*TAG_WIDTH +: TAG_WIDTH]          = tag_q[port_addr[p]];
`ifdef REGFILE_WB_BYPASS_EN
            // A register being re-reserved this cycle keeps showing its stored state.
            if (wb_hit[port_addr[p]] && !rsv_hit[port_addr[p]]) begin
               rd_data[p*OPERAND_WIDTH +: OPERAND_WIDTH] = wb_data;
               rd_busy[p]                                = 1'b0;
            end
`else
`endif
         end
      end
   end

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file: driver pushes expected read-port views into a
// queue, a negedge monitor pops and compares them against both read ports and busy_count.
module tb_scoreboard_register_file;

   localparam int OW = 32;
   localparam int NR = 32;
   localparam int NP = 2;
   localparam int TW = 4;
   localparam int AW = 5;
   localparam int CW = 6;
   localparam int W  = 2 * (OW + 1 + TW) + CW;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              rsv_valid = 1'b0;
   logic [AW-1:0]     rsv_addr = '0;
   logic [TW-1:0]     rsv_tag = '0;
   logic              wb_valid = 1'b0;
   logic [TW-1:0]     wb_tag = '0;
   logic [OW-1:0]     wb_data = '0;
   logic              flush = 1'b0;
   logic [NP*AW-1:0]  rd_addr = '0;
   logic [NP*OW-1:0]  rd_data;
   logic [NP-1:0]     rd_busy;
   logic [NP*TW-1:0]  rd_tag;
   logic [CW-1:0]     busy_count;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   logic         chk_valid = 1'b0;
   int           n_checks = 0;
   int           n_pass = 0;

   scoreboard_register_file #(
      .OPERAND_WIDTH(OW), .NUM_REGS(NR), .NUM_READ_PORTS(NP), .TAG_WIDTH(TW)
   ) dut (
      .clk(clk), .rst(rst),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_tag(rsv_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
      .flush(flush), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
      .busy_count(busy_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
      rsv_valid = 1'b0;
      wb_valid  = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic reserve(input int addr, input int tag);
      rsv_valid = 1'b1;
      rsv_addr  = AW'(addr);
      rsv_tag   = TW'(tag);
      tick();
   endtask

   task automatic writeback(input int tag, input logic [OW-1:0] data);
      wb_valid = 1'b1;
      wb_tag   = TW'(tag);
      wb_data  = data;
      tick();
   endtask

   task automatic check(input string name,
                        input int a0, input logic [OW-1:0] d0, input logic b0, input int t0,
                        input int a1, input logic [OW-1:0] d1, input logic b1, input int t1,
                        input int cnt);
      rd_addr = {AW'(a1), AW'(a0)};
      exp_q.push_back({d0, b0, TW'(t0), d1, b1, TW'(t1), CW'(cnt)});
      name_q.push_back(name);
      chk_valid = 1'b1;
      @(negedge clk);
      #1;
      chk_valid = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (chk_valid) begin
         logic [W-1:0] act;
         logic [W-1:0] exp;
         string        nm;
         act = {rd_data[0 +: OW], rd_busy[0], rd_tag[0 +: TW],
                rd_data[OW +: OW], rd_busy[1], rd_tag[TW +: TW], busy_count};
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_sample: got %h required nothing queued", act);
         end else begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            if (act === exp) n_pass++;
            else $display("FAIL %s: got %h required %h", nm, act, exp);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();

      check("reset_state", 5, 0, 0, 0, 3, 0, 0, 0, 0);

      // reserve then write-back
      reserve(3, 7);
      check("rsv_r3", 3, 0, 1, 7, 0, 0, 0, 0, 1);
      writeback(7, 32'hDEADBEEF);
      check("wb_r3", 3, 32'hDEADBEEF, 0, 7, 0, 0, 0, 0, 0);

      // multi-match, stale tag on non-busy register
      reserve(6, 2);
      writeback(2, 32'h66);
      reserve(4, 2);
      reserve(9, 2);
      check("rsv_r4_r9", 4, 0, 1, 2, 9, 0, 1, 2, 2);
      writeback(2, 32'h55);
      check("wb_multi", 4, 32'h55, 0, 2, 9, 32'h55, 0, 2, 0);
      check("stale_tag", 6, 32'h66, 0, 2, 3, 32'hDEADBEEF, 0, 7, 0);

      // reserve wins over write-back on the same register
      reserve(3, 1);
      reserve(10, 1);
      check("rsv_r3_r10", 3, 32'hDEADBEEF, 1, 1, 10, 0, 1, 1, 2);
      rsv_valid = 1'b1; rsv_addr = 5'd3; rsv_tag = 4'd5;
      writeback(1, 32'h11);
      check("rsv_beats_wb", 3, 32'hDEADBEEF, 1, 5, 10, 32'h11, 0, 1, 1);
      writeback(5, 32'h33);
      check("wb_new_tag", 3, 32'h33, 0, 5, 10, 32'h11, 0, 1, 0);

      // flush with concurrent reserve and write-back
      reserve(1, 1);
      reserve(2, 2);
      reserve(3, 3);
      check("three_busy", 1, 0, 1, 1, 2, 0, 1, 2, 3);
      flush = 1'b1;
      rsv_valid = 1'b1; rsv_addr = 5'd7; rsv_tag = 4'd8;
      writeback(2, 32'h22);
      check("flush_r7_r2", 7, 0, 0, 0, 2, 32'h22, 0, 2, 0);
      check("flush_keep", 1, 0, 0, 1, 3, 32'h33, 0, 3, 0);

      // register 0 is hardwired
      reserve(0, 3);
      check("r0_rsv", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      writeback(0, 32'hAB);
      check("r0_wb", 0, 0, 0, 0, 1, 0, 0, 1, 0);

      // write-back visibility in the broadcast cycle
      reserve(8, 4);
      wb_valid = 1'b1; wb_tag = 4'd4; wb_data = 32'h99;
`ifdef REGFILE_WB_BYPASS_EN
      check("bypass_same_cycle", 8, 32'h99, 0, 4, 0, 0, 0, 0, 1);
`else
      check("no_bypass_same_cycle", 8, 0, 1, 4, 0, 0, 0, 0, 1);
`endif
      tick();
      check("wb_r8_after", 8, 32'h99, 0, 4, 0, 0, 0, 0, 0);

      // asynchronous reset mid-run
      reserve(5, 9);
      check("rsv_r5", 5, 0, 1, 9, 8, 32'h99, 0, 4, 1);
      #2 rst = 1'b0;
      check("reset_mid_run", 5, 0, 0, 0, 3, 0, 0, 0, 0);
      check("reset_mid_run2", 8, 0, 0, 0, 10, 0, 0, 0, 0);
      #1 rst = 1'b1;
      tick();
      check("after_reset", 5, 0, 0, 0, 2, 0, 0, 0, 0);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
